// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: parameter defaults, FSM
// encoding and an index-width helper.
package fifo_arb_pkg;

   localparam int unsigned NUM_REQ_DEF   = 4;
   localparam int unsigned DATA_W_DEF    = 16;
   localparam int unsigned MAX_BURST_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      STALL = 2'd2
   } arb_state_e;

   // Width of an index into n items; a single item still needs one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the write arbiter.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF
);
   localparam int unsigned GID_W = idx_w(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_wen;
   logic [DATA_W-1:0]         fifo_wdata;
   logic                      fifo_full;
   logic                      fifo_prog_full;
   logic [GID_W-1:0]          grant_id;
   logic                      busy;

   modport master (
      input  req_valid, req_data, fifo_full, fifo_prog_full,
      output req_ready, fifo_wen, fifo_wdata, grant_id, busy
   );

   modport slave (
      output req_valid, req_data, fifo_full, fifo_prog_full,
      input  req_ready, fifo_wen, fifo_wdata, grant_id, busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after the
// start pointer, wrapping modulo NUM_REQ.
module rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
   localparam int unsigned GID_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [GID_W-1:0]   start_i,
   output logic [GID_W-1:0]   winner_o,
   output logic               any_valid_o
);

   // Scan farthest offset first so the nearest valid requester is written last.
   always_comb begin
      logic [GID_W-1:0] idx;
      winner_o = '0;
      idx      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = GID_W'((32'(start_i) + NUM_REQ - 1 - k) % NUM_REQ);
         if (valid_i[idx]) begin
            winner_o = idx;
         end
      end
   end

   assign any_valid_o = |valid_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ beat streams into one FIFO write
// port, with full/prog-full throttling and registered write outputs.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   fifo_wr_arbiter_if.master  bus
);

   localparam int unsigned GID_W = idx_w(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e        state_q, state_d;
   logic [GID_W-1:0]  grant_q, grant_d;
   logic [GID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wen_q, wen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              throttle;
   logic              grant_valid;
   logic              burst_end;
   logic [GID_W-1:0]  next_ptr;
   logic [GID_W-1:0]  arb_start;
   logic [GID_W-1:0]  winner;
   logic              any_valid;
   logic [DATA_W-1:0] data_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
   end

   assign throttle    = bus.fifo_full | bus.fifo_prog_full;
   assign grant_valid = bus.req_valid[grant_q];
   assign next_ptr    = (grant_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_q + GID_W'(1);
   // At burst end the search already starts past the outgoing holder.
   assign arb_start   = (state_q == IDLE) ? rr_ptr_q : next_ptr;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .valid_i     (bus.req_valid),
      .start_i     (arb_start),
      .winner_o    (winner),
      .any_valid_o (any_valid)
   );

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         wen_q    <= 1'b0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      burst_end = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_valid && !throttle) begin
               state_d = GRANT;
               grant_d = winner;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (throttle) begin
               state_d = STALL;
            end else if (!grant_valid) begin
               burst_end = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                  burst_end = 1'b1;
               end
            end
         end
         STALL: begin
            if (!throttle) begin
               if (!grant_valid) begin
                  burst_end = 1'b1;
               end else begin
                  state_d = GRANT;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Rotate and re-arbitrate in the same cycle; throttle is known low here.
      if (burst_end) begin
         rr_ptr_d = next_ptr;
         cnt_d    = '0;
         if (any_valid) begin
            state_d = GRANT;
            grant_d = winner;
         end else begin
            state_d = IDLE;
         end
      end
   end

   // Output logic
   always_comb begin
      bus.req_ready = '0;
      wen_d         = 1'b0;
      wdata_d       = wdata_q;
      if (state_q == GRANT && !throttle) begin
         bus.req_ready[grant_q] = 1'b1;
         if (grant_valid) begin
            wen_d   = 1'b1;
            wdata_d = data_arr[grant_q];
         end
      end
   end

   assign bus.fifo_wen   = wen_q;
   assign bus.fifo_wdata = wdata_q;
   assign bus.grant_id   = grant_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model and a per-requester order scoreboard.
module tb_fifo_wr_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned MB = 4;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;
   int seq [N];

   // Beat payload: requester id in the top nibble, per-requester sequence below.
   task automatic set_data();
      for (int i = 0; i < N; i++) begin
         bus.req_data[i*DW +: DW] = {4'(i), 12'(seq[i])};
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn               = 1'b0;
      bus.req_valid      = '0;
      bus.fifo_full      = 1'b0;
      bus.fifo_prog_full = 1'b0;
      for (int i = 0; i < N; i++) seq[i] = 0;
      set_data();
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn               = 1'b0;
      bus.req_valid      = '1;
      bus.fifo_full      = 1'b0;
      bus.fifo_prog_full = 1'b0;
      for (int i = 0; i < N; i++) seq[i] = i + 5;
      set_data();
      tick();
      tick();
      checks += 5;
      if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
      if (bus.fifo_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", bus.fifo_wen); end
      if (bus.fifo_wdata !== 16'h0000) begin failures++; $display("FAIL reset_wdata got=%h exp=0000", bus.fifo_wdata); end
      if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", bus.grant_id); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_round_robin();
      int g;
      int s;
      do_reset();
      bus.req_valid = '1;
      tick();
      for (int k = 0; k < 20; k++) begin
         g = (k / 4) % 4;
         s = (k / 16) * 4 + k % 4;
         set_data();
         #1;
         checks += 2;
         if (bus.grant_id !== 2'(g)) begin failures++; $display("FAIL rr_grant k=%0d got=%0d exp=%0d", k, bus.grant_id, g); end
         if (bus.req_ready !== 4'(1 << g)) begin failures++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, bus.req_ready, 4'(1 << g)); end
         tick();
         seq[g]++;
         checks += 2;
         if (bus.fifo_wen !== 1'b1) begin failures++; $display("FAIL rr_wen k=%0d got=%b exp=1", k, bus.fifo_wen); end
         if (bus.fifo_wdata !== {4'(g), 12'(s)}) begin failures++; $display("FAIL rr_wdata k=%0d got=%h exp=%h", k, bus.fifo_wdata, {4'(g), 12'(s)}); end
      end
   endtask

   task automatic test_single_requester();
      do_reset();
      bus.req_valid = 4'b0100;
      tick();
      for (int k = 0; k < 10; k++) begin
         set_data();
         #1;
         checks += 2;
         if (bus.grant_id !== 2'd2) begin failures++; $display("FAIL single_grant k=%0d got=%0d exp=2", k, bus.grant_id); end
         if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready k=%0d got=%b exp=0100", k, bus.req_ready); end
         tick();
         seq[2]++;
         checks += 2;
         if (bus.fifo_wen !== 1'b1) begin failures++; $display("FAIL single_wen k=%0d got=%b exp=1", k, bus.fifo_wen); end
         if (bus.fifo_wdata !== 16'h2000 + 16'(k)) begin failures++; $display("FAIL single_wdata k=%0d got=%h exp=%h", k, bus.fifo_wdata, 16'h2000 + 16'(k)); end
      end
      bus.req_valid = 4'b0000;
      tick();
      checks += 3;
      if (bus.fifo_wen !== 1'b0) begin failures++; $display("FAIL single_end_wen got=%b exp=0", bus.fifo_wen); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_end_busy got=%b exp=0", bus.busy); end
      if (bus.fifo_wdata !== 16'h2009) begin failures++; $display("FAIL single_hold_wdata got=%h exp=2009", bus.fifo_wdata); end
   endtask

   task automatic test_throttle();
      do_reset();
      bus.req_valid = 4'b0011;
      tick();
      for (int b = 0; b < 4; b++) begin
         if (b == 2) begin
            bus.fifo_prog_full = 1'b1;
            for (int t = 0; t < 5; t++) begin
               #1;
               checks += 4;
               if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL thr_ready t=%0d got=%b exp=0000", t, bus.req_ready); end
               tick();
               if (bus.fifo_wen !== 1'b0) begin failures++; $display("FAIL thr_wen t=%0d got=%b exp=0", t, bus.fifo_wen); end
               if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL thr_grant t=%0d got=%0d exp=0", t, bus.grant_id); end
               if (bus.busy !== 1'b1) begin failures++; $display("FAIL thr_busy t=%0d got=%b exp=1", t, bus.busy); end
            end
            bus.fifo_prog_full = 1'b0;
            #1;
            checks += 2;
            if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL thr_stall_ready got=%b exp=0000", bus.req_ready); end
            tick();
            if (bus.fifo_wen !== 1'b0) begin failures++; $display("FAIL thr_stall_wen got=%b exp=0", bus.fifo_wen); end
         end
         set_data();
         #1;
         checks += 1;
         if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL thr_beat_ready b=%0d got=%b exp=0001", b, bus.req_ready); end
         tick();
         seq[0]++;
         checks += 2;
         if (bus.fifo_wen !== 1'b1) begin failures++; $display("FAIL thr_beat_wen b=%0d got=%b exp=1", b, bus.fifo_wen); end
         if (bus.fifo_wdata !== 16'(b)) begin failures++; $display("FAIL thr_beat_wdata b=%0d got=%h exp=%h", b, bus.fifo_wdata, 16'(b)); end
      end
      #1;
      checks += 2;
      if (bus.grant_id !== 2'd1) begin failures++; $display("FAIL thr_rotate_grant got=%0d exp=1", bus.grant_id); end
      if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL thr_rotate_ready got=%b exp=0010", bus.req_ready); end
   endtask

   task automatic test_drop_valid();
      do_reset();
      bus.req_valid = 4'b1010;
      tick();
      set_data();
      #1;
      checks += 1;
      if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL drop_ready got=%b exp=0010", bus.req_ready); end
      tick();
      seq[1]++;
      checks += 2;
      if (bus.fifo_wen !== 1'b1) begin failures++; $display("FAIL drop_wen got=%b exp=1", bus.fifo_wen); end
      if (bus.fifo_wdata !== 16'h1000) begin failures++; $display("FAIL drop_wdata got=%h exp=1000", bus.fifo_wdata); end
      bus.req_valid = 4'b1000;
      tick();
      checks += 3;
      if (bus.grant_id !== 2'd3) begin failures++; $display("FAIL drop_next_grant got=%0d exp=3", bus.grant_id); end
      if (dut.rr_ptr_q !== 2'd2) begin failures++; $display("FAIL drop_rr_ptr got=%0d exp=2", dut.rr_ptr_q); end
      if (bus.fifo_wen !== 1'b0) begin failures++; $display("FAIL drop_gap_wen got=%b exp=0", bus.fifo_wen); end
      #1;
      checks += 1;
      if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL drop_next_ready got=%b exp=1000", bus.req_ready); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      bus.req_valid = 4'b0010;
      tick();
      for (int b = 0; b < 2; b++) begin
         set_data();
         tick();
         seq[1]++;
      end
      set_data();
      #1;
      checks += 1;
      if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL rstmid_pre_ready got=%b exp=0010", bus.req_ready); end
      #1;
      rstn = 1'b0;
      #1;
      checks += 5;
      if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rstmid_ready got=%b exp=0000", bus.req_ready); end
      if (bus.fifo_wen !== 1'b0) begin failures++; $display("FAIL rstmid_wen got=%b exp=0", bus.fifo_wen); end
      if (bus.fifo_wdata !== 16'h0000) begin failures++; $display("FAIL rstmid_wdata got=%h exp=0000", bus.fifo_wdata); end
      if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL rstmid_grant got=%0d exp=0", bus.grant_id); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
      bus.req_valid = '1;
      tick();
      tick();
      rstn = 1'b1;
      tick();
      #1;
      checks += 3;
      if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL rstmid_first_grant got=%0d exp=0", bus.grant_id); end
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL rstmid_first_busy got=%b exp=1", bus.busy); end
      if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rstmid_first_ready got=%b exp=0001", bus.req_ready); end
   endtask

   // First valid requester at or after p, wrapping around.
   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic test_random();
      int          holder = -1;
      int          gid    = 0;
      int          beats  = 0;
      int          ptr    = 0;
      bit          stalled = 1'b0;
      bit          prev_th = 1'b0;
      bit          had;
      bit          th;
      bit          acc;
      bit          end_b;
      logic        exp_wen   = 1'b0;
      logic [15:0] exp_wdata = 16'h0000;
      logic [3:0]  exp_ready;
      logic [3:0]  v;
      logic [3:0]  acc_obs;
      int          sb_seq [N];
      int          id;
      do_reset();
      for (int i = 0; i < N; i++) sb_seq[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 7);
         bus.req_valid      = v;
         bus.fifo_full      = ($urandom_range(0, 9) == 0);
         bus.fifo_prog_full = ($urandom_range(0, 6) == 0);
         th = bus.fifo_full | bus.fifo_prog_full;
         set_data();
         #1;
         // Ready only for a settled, unstalled grant holder with no throttle.
         exp_ready = (holder >= 0 && !stalled && !th) ? 4'(1 << holder) : 4'b0000;
         checks++;
         if (bus.req_ready !== exp_ready) begin failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_ready); end
         acc_obs = bus.req_ready & v;
         acc = (exp_ready != 4'b0000) && v[holder];
         if (acc) exp_wdata = {4'(holder), 12'(seq[holder])};
         exp_wen = acc;
         had   = (holder >= 0);
         end_b = 1'b0;
         if (!had) begin
            if (v != 4'b0000 && !th) begin
               holder = pick(v, ptr);
               gid    = holder;
               beats  = 0;
            end
         end else if (!th) begin
            if (!v[holder]) end_b = 1'b1;
            else if (!stalled) begin
               beats++;
               if (beats == MB) end_b = 1'b1;
            end
         end
         if (end_b) begin
            ptr   = (holder + 1) % N;
            beats = 0;
            if (v != 4'b0000) begin
               holder = pick(v, ptr);
               gid    = holder;
            end else begin
               holder = -1;
            end
         end
         stalled = had && th;
         tick();
         for (int i = 0; i < N; i++) if (acc_obs[i]) seq[i]++;
         checks += 4;
         if (bus.fifo_wen !== exp_wen) begin failures++; $display("FAIL rand_wen c=%0d got=%b exp=%b", c, bus.fifo_wen, exp_wen); end
         if (bus.fifo_wdata !== exp_wdata) begin failures++; $display("FAIL rand_wdata c=%0d got=%h exp=%h", c, bus.fifo_wdata, exp_wdata); end
         if (bus.grant_id !== 2'(gid)) begin failures++; $display("FAIL rand_grant c=%0d got=%0d exp=%0d", c, bus.grant_id, gid); end
         if (bus.busy !== (holder >= 0)) begin failures++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, bus.busy, holder >= 0); end
         if (bus.fifo_wen === 1'b1) begin
            id = int'(bus.fifo_wdata[15:12]);
            checks += 2;
            if (prev_th) begin failures++; $display("FAIL sb_wen_after_throttle c=%0d got=1 exp=0", c); end
            if (id >= N || bus.fifo_wdata[11:0] !== 12'(sb_seq[id % N])) begin
               failures++;
               $display("FAIL sb_order c=%0d got=%h exp_seq=%0d", c, bus.fifo_wdata, sb_seq[id % N]);
            end
            if (id < N) sb_seq[id]++;
         end
         prev_th = th;
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (sb_seq[i] != seq[i]) begin failures++; $display("FAIL sb_count req=%0d got=%0d exp=%0d", i, sb_seq[i], seq[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_requester();
      test_throttle();
      test_drop_valid();
      test_reset_mid_burst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
